// File: rtl/bullet_pool_if.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool_if
// Purpose  : Player/alien inputs and bullet/grid/score outputs of bullet_pool.
// Revision : 1.0 - initial release
// ============================================================================
interface bullet_pool_if #(
    parameter int NUM_BULLETS = 4,
    parameter int ALIEN_ROWS  = 5,
    parameter int ALIEN_COLS  = 10,
    parameter int SCORE_W     = 10
);
    logic                             Fire;
    logic                             New_Wave;
    logic [8:0]                       Player_Row;
    logic [9:0]                       Player_Col;
    logic [8:0]                       Aliens_Row;
    logic [9:0]                       Aliens_Col;
    logic [NUM_BULLETS-1:0]           Bullet_Valid;
    logic [9*NUM_BULLETS-1:0]         Bullet_Rows;
    logic [10*NUM_BULLETS-1:0]        Bullet_Cols;
    logic [ALIEN_ROWS*ALIEN_COLS-1:0] Aliens_Grid;
    logic                             Aliens_Defeated;
    logic                             Hit_Pulse;
    logic                             Fire_Dropped;
    logic [SCORE_W-1:0]               Score;

    modport master (
        output Fire, New_Wave, Player_Row, Player_Col, Aliens_Row, Aliens_Col,
        input  Bullet_Valid, Bullet_Rows, Bullet_Cols, Aliens_Grid,
               Aliens_Defeated, Hit_Pulse, Fire_Dropped, Score
    );

    modport slave (
        input  Fire, New_Wave, Player_Row, Player_Col, Aliens_Row, Aliens_Col,
        output Bullet_Valid, Bullet_Rows, Bullet_Cols, Aliens_Grid,
               Aliens_Defeated, Hit_Pulse, Fire_Dropped, Score
    );
endinterface
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool
// Purpose  : Multi-slot player bullet engine with alien grid collision/score.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int ALIEN_ROWS  = 5,
    parameter int ALIEN_COLS  = 10,
    parameter int CELL_W_LOG2 = 5,
    parameter int CELL_H_LOG2 = 5,
    parameter int ALIEN_W     = 24,
    parameter int ALIEN_H     = 16,
    parameter int STEP        = 4,
    parameter int MUZZLE_OFS  = 8,
    parameter int COOLDOWN    = 3,
    parameter int SCORE_W     = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    bullet_pool_if.slave bus
);
    localparam int NCELLS = ALIEN_ROWS * ALIEN_COLS;
    localparam int CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int CNT_W  = $clog2(NUM_BULLETS + 1);

    localparam logic [8:0]         Y_MASK    = 9'((1 << CELL_H_LOG2) - 1);
    localparam logic [9:0]         X_MASK    = 10'((1 << CELL_W_LOG2) - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic                   fire_q;
    logic                   fire_edge_q;
    logic [CD_W-1:0]        cd;
    logic [NUM_BULLETS-1:0] valid;
    logic [8:0]             row [NUM_BULLETS];
    logic [9:0]             col [NUM_BULLETS];
    logic [NCELLS-1:0]      grid;
    logic [SCORE_W-1:0]     score;
    logic                   hit_pulse;
    logic                   fire_dropped;

    logic [NCELLS-1:0]      cell_hit [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] hit;
    logic [NUM_BULLETS-1:0] counted;
    logic [NCELLS-1:0]      claimed;
    logic [CNT_W-1:0]       n_counted;
    logic [SCORE_W:0]       score_sum;
    logic [SCORE_W-1:0]     score_next;
    logic [NUM_BULLETS-1:0] spawn_sel;
    logic                   slot_free;
    logic                   accept;

    // Per-slot collision: one-hot vector of the live cell the bullet sits in.
    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        logic [8:0]        dy;
        logic [9:0]        dx;
        logic [8:0]        dy_cell;
        logic [9:0]        dx_cell;
        logic              in_box;
        logic [NCELLS-1:0] hits_here;

        assign dy      = row[i] - bus.Aliens_Row;
        assign dx      = col[i] - bus.Aliens_Col;
        assign dy_cell = dy >> CELL_H_LOG2;
        assign dx_cell = dx >> CELL_W_LOG2;
        assign in_box  = valid[i]
                      && (row[i] >= bus.Aliens_Row)
                      && (col[i] >= bus.Aliens_Col)
                      && ((dy & Y_MASK) < 9'(ALIEN_H))
                      && ((dx & X_MASK) < 10'(ALIEN_W));

        always_comb begin
            hits_here = '0;
            for (int k = 0; k < NCELLS; k++) begin
                hits_here[k] = in_box && grid[k]
                            && (dy_cell == 9'(k / ALIEN_COLS))
                            && (dx_cell == 10'(k % ALIEN_COLS));
            end
        end

        assign cell_hit[i] = hits_here;
        assign hit[i]      = |hits_here;

        assign bus.Bullet_Rows[9*i +: 9]   = row[i];
        assign bus.Bullet_Cols[10*i +: 10] = col[i];
    end

    // A cell already claimed by a lower slot this cycle does not score again.
    always_comb begin
        claimed   = '0;
        counted   = '0;
        n_counted = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            counted[i] = hit[i] && ((cell_hit[i] & claimed) == '0);
            claimed    = claimed | cell_hit[i];
            n_counted  = n_counted + CNT_W'(counted[i]);
        end
        score_sum  = {1'b0, score} + (SCORE_W + 1)'(n_counted);
        score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    assign spawn_sel = ~valid & (valid + 1'b1);
    assign slot_free = |(~valid);
    assign accept    = fire_edge_q && (cd == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_q       <= 1'b0;
            fire_edge_q  <= 1'b0;
            cd           <= '0;
            valid        <= '0;
            grid         <= '1;
            score        <= '0;
            hit_pulse    <= 1'b0;
            fire_dropped <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                row[i] <= '0;
                col[i] <= '0;
            end
        end else begin
            fire_q      <= bus.Fire;
            fire_edge_q <= bus.Fire & ~fire_q;
            if (bus.New_Wave) begin
                cd           <= '0;
                valid        <= '0;
                grid         <= '1;
                hit_pulse    <= 1'b0;
                fire_dropped <= 1'b0;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    row[i] <= '0;
                    col[i] <= '0;
                end
            end else begin
                if (accept) begin
                    cd <= CD_W'(COOLDOWN);
                end else if (cd != '0) begin
                    cd <= cd - CD_W'(1);
                end
                fire_dropped <= accept && !slot_free;
                hit_pulse    <= |counted;
                grid         <= grid & ~claimed;
                score        <= score_next;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (valid[i]) begin
                        if (hit[i] || (row[i] < 9'(STEP))) begin
                            valid[i] <= 1'b0;
                        end else begin
                            row[i] <= row[i] - 9'(STEP);
                        end
                    end else if (accept && spawn_sel[i]) begin
                        valid[i] <= 1'b1;
                        row[i]   <= bus.Player_Row;
                        col[i]   <= bus.Player_Col + 10'(MUZZLE_OFS);
                    end
                end
            end
        end
    end

    assign bus.Bullet_Valid    = valid;
    assign bus.Aliens_Grid     = grid;
    assign bus.Aliens_Defeated = ~|grid;
    assign bus.Hit_Pulse       = hit_pulse;
    assign bus.Fire_Dropped    = fire_dropped;
    assign bus.Score           = score;
endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_pool
// Purpose  : Scoreboard bench for bullet_pool with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_pool;
    localparam logic [63:0] ALL = (64'd1 << 50) - 64'd1;
    localparam int K_VALID = 0, K_ROW = 1, K_COL = 2, K_GRID = 3,
                   K_SCORE = 4, K_HIT = 5, K_DROP = 6, K_DEF = 7;

    typedef struct {
        int          cyc;
        int          kind;
        int          slot;
        logic [63:0] val;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];

    bullet_pool_if #(.NUM_BULLETS(4), .ALIEN_ROWS(5), .ALIEN_COLS(10), .SCORE_W(10)) bus ();

    bullet_pool #(
        .NUM_BULLETS(4), .ALIEN_ROWS(5), .ALIEN_COLS(10), .CELL_W_LOG2(5),
        .CELL_H_LOG2(5), .ALIEN_W(24), .ALIEN_H(16), .STEP(4),
        .MUZZLE_OFS(8), .COOLDOWN(3), .SCORE_W(10)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_VALID: return "valid";
            K_ROW:   return "row";
            K_COL:   return "col";
            K_GRID:  return "grid";
            K_SCORE: return "score";
            K_HIT:   return "hit_pulse";
            K_DROP:  return "fire_dropped";
            default: return "defeated";
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [63:0] act;
        logic [35:0] rv;
        logic [39:0] cv;
        rv = bus.Bullet_Rows;
        cv = bus.Bullet_Cols;
        case (e.kind)
            K_VALID: act = 64'(bus.Bullet_Valid);
            K_ROW:   act = 64'(rv[9*e.slot +: 9]);
            K_COL:   act = 64'(cv[10*e.slot +: 10]);
            K_GRID:  act = 64'(bus.Aliens_Grid);
            K_SCORE: act = 64'(bus.Score);
            K_HIT:   act = 64'(bus.Hit_Pulse);
            K_DROP:  act = 64'(bus.Fire_Dropped);
            default: act = 64'(bus.Aliens_Defeated);
        endcase
        n_checks++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s[%0d] cyc %0d: got %0d, expected %0d",
                      kname(e.kind), e.slot, e.cyc, act, e.val);
    endtask

    // Monitor: consume every expectation due in the current cycle.
    always @(negedge Clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic ex(input int dc, input int kind, input int slot, input logic [63:0] v);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.slot = slot;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic new_wave(input logic [63:0] exp_score);
        bus.New_Wave = 1'b1;
        ex(1, K_VALID, 0, 0);
        ex(1, K_GRID, 0, ALL);
        ex(1, K_SCORE, 0, exp_score);
        ex(1, K_DEF, 0, 0);
        step(1);
        bus.New_Wave = 1'b0;
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: cyc %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        bus.Fire = 1'b0;
        bus.New_Wave = 1'b0;
        bus.Player_Row = '0;
        bus.Player_Col = '0;
        bus.Aliens_Row = 9'd100;
        bus.Aliens_Col = 10'd500;
        step(2);
        ex(1, K_VALID, 0, 0);
        ex(1, K_GRID, 0, ALL);
        ex(1, K_SCORE, 0, 0);
        ex(1, K_DEF, 0, 0);
        ex(1, K_HIT, 0, 0);
        ex(1, K_DROP, 0, 0);
        step(1);
        Reset = 1'b0;
        step(1);

        // Spawn at (440, 308) and climb 4 rows per cycle.
        bus.Player_Row = 9'd440;
        bus.Player_Col = 10'd300;
        bus.Fire = 1'b1;
        ex(1, K_VALID, 0, 0);
        ex(2, K_VALID, 0, 1);
        ex(2, K_ROW, 0, 440);
        ex(2, K_COL, 0, 308);
        ex(3, K_ROW, 0, 436);
        ex(4, K_ROW, 0, 432);
        step(1);
        bus.Fire = 1'b0;
        step(3);
        new_wave(0);

        // Hit on cell (0,0) at row 112, col 105.
        bus.Aliens_Col = 10'd100;
        bus.Player_Row = 9'd120;
        bus.Player_Col = 10'd97;
        bus.Fire = 1'b1;
        ex(2, K_ROW, 0, 120);
        ex(2, K_COL, 0, 105);
        ex(4, K_ROW, 0, 112);
        ex(4, K_VALID, 0, 1);
        ex(4, K_HIT, 0, 0);
        ex(5, K_VALID, 0, 0);
        ex(5, K_GRID, 0, ALL & ~64'd1);
        ex(5, K_SCORE, 0, 1);
        ex(5, K_HIT, 0, 1);
        ex(6, K_HIT, 0, 0);
        step(1);
        bus.Fire = 1'b0;
        step(5);

        // Col 127 is outside the hit box width and passes through.
        bus.Player_Col = 10'd119;
        bus.Fire = 1'b1;
        ex(2, K_COL, 0, 127);
        ex(4, K_ROW, 0, 112);
        ex(5, K_VALID, 0, 1);
        ex(5, K_ROW, 0, 108);
        ex(5, K_HIT, 0, 0);
        ex(7, K_ROW, 0, 100);
        ex(8, K_ROW, 0, 96);
        ex(8, K_SCORE, 0, 1);
        step(1);
        bus.Fire = 1'b0;
        step(8);
        new_wave(1);

        // Two slots meet in cell (4,1) on the same cycle.
        bus.Player_Col = 10'd130;
        bus.Player_Row = 9'd264;
        bus.Fire = 1'b1;
        ex(2, K_VALID, 0, 1);
        ex(6, K_VALID, 0, 3);
        ex(6, K_ROW, 0, 248);
        ex(6, K_ROW, 1, 248);
        ex(8, K_ROW, 0, 240);
        ex(8, K_ROW, 1, 240);
        ex(9, K_VALID, 0, 0);
        ex(9, K_GRID, 0, ALL & ~(64'd1 << 41));
        ex(9, K_SCORE, 0, 2);
        ex(9, K_HIT, 0, 1);
        ex(10, K_HIT, 0, 0);
        step(1);
        bus.Fire = 1'b0;
        step(3);
        bus.Player_Row = 9'd248;
        bus.Fire = 1'b1;
        step(1);
        bus.Fire = 1'b0;
        step(7);

        // Fire edges every 2 cycles: cooldown rejects every other; 5th accept drops.
        bus.Aliens_Col = 10'd900;
        bus.Player_Row = 9'd400;
        bus.Player_Col = 10'd300;
        ex(2, K_VALID, 0, 1);
        ex(4, K_VALID, 0, 1);
        ex(6, K_VALID, 0, 3);
        ex(6, K_DROP, 0, 0);
        ex(10, K_VALID, 0, 7);
        ex(14, K_VALID, 0, 15);
        ex(18, K_DROP, 0, 1);
        ex(18, K_VALID, 0, 15);
        ex(18, K_ROW, 0, 336);
        ex(18, K_ROW, 3, 384);
        ex(19, K_ROW, 3, 380);
        ex(19, K_DROP, 0, 0);
        for (int k = 0; k < 10; k++) begin
            bus.Fire = 1'b1;
            step(1);
            bus.Fire = 1'b0;
            step(1);
        end
        new_wave(2);

        // Shoot every alien directly inside its hit box.
        bus.Aliens_Col = 10'd100;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                bus.Player_Row = 9'(108 + 32 * r);
                bus.Player_Col = 10'(96 + 32 * c);
                bus.Fire = 1'b1;
                ex(3, K_HIT, 0, 1);
                ex(3, K_SCORE, 0, 64'(r * 10 + c + 3));
                ex(4, K_HIT, 0, 0);
                step(1);
                bus.Fire = 1'b0;
                step(3);
            end
        end
        ex(1, K_DEF, 0, 1);
        ex(1, K_GRID, 0, 0);
        step(1);
        new_wave(52);

        // Row 3 is below STEP: retires at the top without scoring.
        bus.Player_Row = 9'd3;
        bus.Player_Col = 10'd300;
        bus.Fire = 1'b1;
        ex(2, K_VALID, 0, 1);
        ex(2, K_ROW, 0, 3);
        ex(3, K_VALID, 0, 0);
        ex(3, K_SCORE, 0, 52);
        ex(3, K_HIT, 0, 0);
        step(1);
        bus.Fire = 1'b0;
        step(4);

        // Asynchronous reset mid-cycle with a bullet in flight.
        bus.Player_Row = 9'd400;
        bus.Fire = 1'b1;
        ex(2, K_VALID, 0, 1);
        step(1);
        bus.Fire = 1'b0;
        step(3);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        ex(0, K_VALID, 0, 0);
        ex(0, K_ROW, 0, 0);
        ex(0, K_COL, 0, 0);
        ex(0, K_GRID, 0, ALL);
        ex(0, K_SCORE, 0, 0);
        ex(0, K_HIT, 0, 0);
        ex(0, K_DROP, 0, 0);
        step(2);
        Reset = 1'b0;
        step(3);

        while (q.size() > 0) begin
            n_checks++;
            $display("FAIL %s[%0d] cyc %0d: never checked, expected %0d",
                     kname(q[0].kind), q[0].slot, q[0].cyc, q[0].val);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
